// File: rtl/pool_pkg.sv
// Shared types and helpers for the ReLU / 2x2 max-pool stage.
// Helpers work at 64 bits; callers sign-extend and truncate.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } pool_state_t;

  localparam int MAX_W = 64;

  function automatic logic signed [MAX_W-1:0] relu(
    input logic signed [MAX_W-1:0] x
  );
    return (x < 0) ? '0 : x;
  endfunction

  // Only the upper clamp is needed: inputs are post-ReLU.
  function automatic logic signed [7:0] sat_s8(
    input logic signed [MAX_W-1:0] q
  );
    return (q > 127) ? 8'sd127 : q[7:0];
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Half-width row buffer holding the even-row horizontal maxima.
// One write port, one combinational read port, no reset.
module pool_row_buffer #(
  parameter int DEPTH = 1,
  parameter int W     = 32,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Trailing odd column can address past the end; it is never used.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU + 2x2/stride-2 max-pool + shift requantization.
// One pixel per cycle, no backpressure, floor pooling on odd sizes.
module relu_maxpool
  import pool_pkg::*;
#(
  parameter int IN_W  = 3,
  parameter int IN_H  = 3,
  parameter int ACC_W = 32,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] in_pixel,
  input  logic                    in_valid,
  output logic signed [7:0]       out_pixel,
  output logic                    out_valid,
  output logic                    done
);

  localparam int  CW    = $clog2(IN_W);
  localparam int  RW    = $clog2(IN_H);
  localparam int  PD    = IN_W / 2;
  localparam int  AW    = (PD > 1) ? $clog2(PD) : 1;
  localparam bit  W_ODD = (IN_W % 2) == 1;
  localparam bit  H_ODD = (IN_H % 2) == 1;

  pool_state_t state, state_nx;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] pc;

  logic signed [ACC_W-1:0] h;
  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] bq;
  logic signed [ACC_W-1:0] hr_max;
  logic signed [ACC_W-1:0] br_max;
  logic signed [ACC_W-1:0] q;

  logic acc;
  logic col_end;
  logic row_end;
  logic last;
  logic active;
  logic emit;
  logic buf_we;
  logic clr;

  assign acc     = (state == RUN) && in_valid && !start;
  assign clr     = start && (state != FIN);
  assign col_end = col == CW'(IN_W - 1);
  assign row_end = row == RW'(IN_H - 1);
  assign last    = col_end && row_end;

  // Trailing odd column/row is counted but never pooled.
  assign active = acc
                && !(W_ODD && col_end)
                && !(H_ODD && row_end);
  assign emit   = active && row[0] && col[0];
  assign buf_we = active && !row[0] && col[0];
  assign pc     = AW'(col >> 1);

  assign r      = ACC_W'(relu(MAX_W'(in_pixel)));
  assign hr_max = (h > r) ? h : r;
  assign br_max = (bq > r) ? bq : r;
  assign q      = hr_max >>> SHIFT;
  assign done   = state == FIN;

  pool_row_buffer #(
    .DEPTH (PD),
    .W     (ACC_W),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (pc),
    .wdata (hr_max),
    .raddr (pc),
    .rdata (bq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (acc && last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      h         <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) out_pixel <= sat_s8(MAX_W'(q));
      if (clr) begin
        col <= '0;
        row <= '0;
        h   <= '0;
      end else if (acc) begin
        if (last) begin
          col <= '0;
          row <= '0;
        end else if (col_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (active && !col[0]) h <= row[0] ? br_max : r;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: 3x3, 4x4 and 2x2/SHIFT=2 instances.
// Table-driven frames plus restart, async reset and idle-input sequences.
module tb_relu_maxpool;

  logic clk;
  logic rst;
  logic st [3];
  logic vl [3];
  logic signed [31:0] pix_in;
  logic signed [7:0]  op [3];
  logic ov [3];
  logic dn [3];

  int cyc;
  int total;
  int passed;
  int got_v[$];
  int got_c[$];
  int done_n;
  int done_cyc;
  int last_acc;

  typedef struct {
    int id;
    int n;
    int gap;
    int pix[16];
    int nexp;
    int ex[4];
  } vec_t;

  vec_t tbl[8];

  relu_maxpool #(.IN_W(3), .IN_H(3), .ACC_W(32), .SHIFT(0)) u_p3 (
    .clk(clk), .rst(rst), .start(st[0]), .in_pixel(pix_in),
    .in_valid(vl[0]), .out_pixel(op[0]), .out_valid(ov[0]), .done(dn[0])
  );

  relu_maxpool #(.IN_W(4), .IN_H(4), .ACC_W(32), .SHIFT(0)) u_p4 (
    .clk(clk), .rst(rst), .start(st[1]), .in_pixel(pix_in),
    .in_valid(vl[1]), .out_pixel(op[1]), .out_valid(ov[1]), .done(dn[1])
  );

  relu_maxpool #(.IN_W(2), .IN_H(2), .ACC_W(32), .SHIFT(2)) u_p2 (
    .clk(clk), .rst(rst), .start(st[2]), .in_pixel(pix_in),
    .in_valid(vl[2]), .out_pixel(op[2]), .out_valid(ov[2]), .done(dn[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i]) begin
        got_v.push_back(int'(op[i]));
        got_c.push_back(cyc);
      end
      if (dn[i]) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_obs();
    got_v.delete();
    got_c.delete();
    done_n = 0;
    done_cyc = -1;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int id, input int n, input int pix[16],
                      input int gap);
    for (int k = 0; k < n; k++) begin
      vl[id] = 1'b1;
      pix_in = pix[k];
      @(posedge clk);
      #1;
      last_acc = cyc;
      vl[id] = 1'b0;
      if (gap != 0) idle_cycles($urandom_range(1, 3));
    end
  endtask

  // Start pulse carries a poison pixel that must be ignored.
  task automatic run_frame(input int id, input int n, input int pix[16],
                           input int gap);
    clear_obs();
    st[id] = 1'b1;
    vl[id] = 1'b1;
    pix_in = 5000;
    @(posedge clk);
    #1;
    st[id] = 1'b0;
    vl[id] = 1'b0;
    feed(id, n, pix, gap);
    idle_cycles(4);
  endtask

  task automatic check_frame(input string nm, input int nexp,
                             input int ex[4], input bit even);
    chk({nm, ".count"}, got_v.size(), nexp);
    for (int j = 0; j < nexp; j++) begin
      if (j < got_v.size())
        chk($sformatf("%s.out%0d", nm, j), got_v[j], ex[j]);
      else
        chk($sformatf("%s.out%0d", nm, j), -999, ex[j]);
    end
    chk({nm, ".done_n"}, done_n, 1);
    chk({nm, ".done_cyc"}, done_cyc, last_acc);
    if (even && got_c.size() > 0)
      chk({nm, ".last_out_cyc"}, got_c[got_c.size()-1], last_acc);
  endtask

  initial begin
    int ramp16[16];
    int ramp9[16];
    int neg9[16];
    int ex4[4];

    cyc = 0;
    total = 0;
    passed = 0;
    last_acc = 0;
    pix_in = 0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      vl[i] = 1'b0;
    end
    clear_obs();

    for (int i = 0; i < 16; i++) begin
      ramp16[i] = i + 1;
      ramp9[i]  = (i < 9) ? i + 1 : 0;
      neg9[i]   = (i < 9) ? -5 : 0;
    end
    ex4 = '{6, 8, 14, 16};

    tbl[0] = '{id: 0, n: 9, gap: 0, pix: neg9, nexp: 1, ex: '{0, 0, 0, 0}};
    tbl[1] = '{id: 1, n: 16, gap: 0, pix: ramp16, nexp: 4, ex: ex4};
    tbl[2] = '{id: 0, n: 9, gap: 0, pix: ramp9, nexp: 1, ex: '{5, 0, 0, 0}};
    tbl[3] = '{id: 2, n: 4, gap: 0,
               pix: '{1000, 4, -7, 8, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0},
               nexp: 1, ex: '{127, 0, 0, 0}};
    tbl[4] = '{id: 2, n: 4, gap: 0,
               pix: '{100, 4, -7, 8, 0, 0, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0},
               nexp: 1, ex: '{25, 0, 0, 0}};
    tbl[5] = '{id: 1, n: 16, gap: 0,
               pix: '{-1, 3, -9, 2, 7, -4, 0, -2,
                      5, 5, -6, -3, -8, 1, -1, -1},
               nexp: 4, ex: '{7, 2, 5, 0}};
    tbl[6] = '{id: 1, n: 16, gap: 1, pix: ramp16, nexp: 4, ex: ex4};
    tbl[7] = '{id: 0, n: 9, gap: 1, pix: ramp9, nexp: 1, ex: '{5, 0, 0, 0}};

    rst = 1'b1;
    idle_cycles(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset.ov%0d", i), int'(ov[i]), 0);
      chk($sformatf("reset.dn%0d", i), int'(dn[i]), 0);
      chk($sformatf("reset.op%0d", i), int'(op[i]), 0);
    end
    rst = 1'b0;
    idle_cycles(2);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].id, tbl[i].n, tbl[i].pix, tbl[i].gap);
      check_frame($sformatf("vec%0d", i), tbl[i].nexp, tbl[i].ex,
                  tbl[i].id != 0);
    end

    // Restart after 5 pixels; the restart-cycle pixel is dropped.
    clear_obs();
    st[1] = 1'b1;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vl[1] = 1'b1;
      pix_in = 50;
      @(posedge clk);
      #1;
    end
    st[1] = 1'b1;
    pix_in = 9000;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    vl[1] = 1'b0;
    feed(1, 16, ramp16, 0);
    idle_cycles(4);
    check_frame("restart", 4, ex4, 1'b1);

    // Async reset right after a window completes.
    clear_obs();
    st[1] = 1'b1;
    @(posedge clk);
    #1;
    st[1] = 1'b0;
    feed(1, 6, ramp16, 0);
    chk("rst.ov_before", int'(ov[1]), 1);
    chk("rst.op_before", int'(op[1]), 6);
    rst = 1'b1;
    #1;
    chk("rst.ov_async", int'(ov[1]), 0);
    chk("rst.dn_async", int'(dn[1]), 0);
    chk("rst.op_async", int'(op[1]), 0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(2);
    chk("rst.no_out", got_v.size(), 0);
    chk("rst.no_done", done_n, 0);
    run_frame(1, 16, ramp16, 0);
    check_frame("after_rst", 4, ex4, 1'b1);

    // Input while idle must be ignored.
    clear_obs();
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 3; i++) vl[i] = 1'b1;
      pix_in = 100 + k;
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) vl[i] = 1'b0;
    idle_cycles(4);
    chk("idle.no_out", got_v.size(), 0);
    chk("idle.no_done", done_n, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
